// File: rtl/uart_wb_pkg.sv
// Shared state encoding, response codes and command defaults for the UART-to-Wishbone master.
package uart_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [7:0]  RESP_ACK    = 8'h06;
    localparam logic [7:0]  RESP_NAK    = 8'h15;
    localparam logic [7:0]  CMD_WR_DFLT = 8'h57;
    localparam logic [7:0]  CMD_RD_DFLT = 8'h52;
    localparam int unsigned RESP_BYTES  = 5;

    // Left-aligned response image: status byte first, then the read word MSB first
    function automatic logic [RESP_BYTES*8-1:0] resp_image(input logic ok, input logic [31:0] word);
        resp_image = ok ? {RESP_ACK, word} : {RESP_NAK, 32'h0000_0000};
    endfunction

endpackage

// File: rtl/uart_wb_resp_serializer.sv
// Response byte serializer: loads up to RESP_BYTES bytes and hands them out one per valid/ready handshake.
module uart_wb_resp_serializer
    import uart_wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [RESP_BYTES*8-1:0] i_bytes,
    input  logic [2:0]              i_count,
    input  logic                    i_tx_ready,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_last
);
    localparam int unsigned W = RESP_BYTES * 8;

    logic [W-1:0] r_shift;
    logic [2:0]   r_cnt;
    logic         r_valid;
    logic         w_accept;

    assign w_accept   = r_valid && i_tx_ready;
    assign o_last     = w_accept && (r_cnt == 3'd1);
    assign o_tx_data  = r_shift[W-1 -: 8];
    assign o_tx_valid = r_valid;

    // Load a fresh response or advance one byte per accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= {W{1'b0}};
            r_cnt   <= 3'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_bytes;
            r_cnt   <= i_count;
            r_valid <= (i_count != 3'd0);
        end else if (w_accept) begin
            r_shift <= {r_shift[W-9:0], 8'h00};
            r_cnt   <= r_cnt - 3'd1;
            r_valid <= (r_cnt != 3'd1);
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// UART command-frame Wishbone initiator: decodes R/W frames, runs one classic cycle, streams a response.
// Optional inter-byte frame timeout enabled by defining UART_WB_FRAME_TIMEOUT_EN.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int unsigned WB_TIMEOUT    = 255,
`ifdef UART_WB_FRAME_TIMEOUT_EN
    parameter int unsigned FRAME_TIMEOUT = 83340,
`endif
    parameter logic [7:0]  CMD_WR        = CMD_WR_DFLT,
    parameter logic [7:0]  CMD_RD        = CMD_RD_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_frame_err,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        o_busy
);
    localparam int unsigned WAIT_W = $clog2(WB_TIMEOUT + 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_adr;
    logic [31:0]             r_wdat;
    logic [1:0]              r_byte_cnt;
    logic                    r_we;
    logic                    r_we_o;
    logic                    r_cyc;
    logic                    r_busy;
    logic                    r_drop;
    logic [WAIT_W-1:0]       r_wait;
    logic                    w_rx;
    logic                    w_frame_to;
    logic                    w_last;
    logic                    w_load;
    logic [RESP_BYTES*8-1:0] w_load_bytes;
    logic [2:0]              w_load_cnt;
    logic                    w_shift_adr;
    logic                    w_shift_dat;
    logic                    w_latch_we;

    // A framing error always wins over the byte it arrived with
    assign w_rx = i_rx_valid && !i_frame_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_bytes = {(RESP_BYTES*8){1'b0}};
        w_load_cnt   = 3'd0;
        w_shift_adr  = 1'b0;
        w_shift_dat  = 1'b0;
        w_latch_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx) begin
                    if ((i_rx_data == CMD_WR) || (i_rx_data == CMD_RD)) begin
                        w_latch_we  = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_load       = 1'b1;
                        w_load_bytes = resp_image(1'b0, 32'h0000_0000);
                        w_load_cnt   = 3'd1;
                        w_state_nxt  = ST_RESP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (i_frame_err || w_frame_to) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rx) begin
                    w_shift_adr = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = r_we ? ST_WDATA : ST_BUS;
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_WDATA: begin
                if (i_frame_err || w_frame_to) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rx) begin
                    w_shift_dat = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = ST_BUS;
                    end else begin
                        w_state_nxt = ST_WDATA;
                    end
                end else begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_BUS: begin
                // Ack takes priority over the timeout limit in the same cycle
                if (wbm_ack_i) begin
                    w_load       = 1'b1;
                    w_load_bytes = resp_image(1'b1, r_we ? 32'h0000_0000 : wbm_dat_i);
                    w_load_cnt   = r_we ? 3'd1 : 3'd5;
                    w_state_nxt  = ST_RESP;
                end else if (r_wait == WAIT_W'(WB_TIMEOUT - 1)) begin
                    w_load       = 1'b1;
                    w_load_bytes = resp_image(1'b0, 32'h0000_0000);
                    w_load_cnt   = 3'd1;
                    w_state_nxt  = ST_RESP;
                end else begin
                    w_state_nxt = ST_BUS;
                end
            end
            ST_RESP: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame assembly: command direction, byte count, address and write-data shifters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_adr      <= 32'h0000_0000;
            r_wdat     <= 32'h0000_0000;
        end else begin
            if (w_latch_we) begin
                r_we       <= (i_rx_data == CMD_WR);
                r_byte_cnt <= 2'd0;
            end else if (w_shift_adr || w_shift_dat) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_shift_adr) begin
                r_adr <= {r_adr[23:0], i_rx_data};
            end
            if (w_shift_dat) begin
                r_wdat <= {r_wdat[23:0], i_rx_data};
            end
        end
    end

    // Bus wait counter restarts on every entry to BUS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= {WAIT_W{1'b0}};
        end else if (r_state == ST_BUS) begin
            r_wait <= r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait <= {WAIT_W{1'b0}};
        end
    end

    // Registered Wishbone strobes, busy flag and the discarded-byte pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc  <= 1'b0;
            r_we_o <= 1'b0;
            r_busy <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_cyc  <= (w_state_nxt == ST_BUS);
            r_we_o <= (w_state_nxt == ST_BUS) && r_we;
            r_busy <= (w_state_nxt != ST_IDLE);
            r_drop <= w_rx && ((r_state == ST_BUS) || (r_state == ST_RESP));
        end
    end

`ifdef UART_WB_FRAME_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(FRAME_TIMEOUT + 1);

    logic [IDLE_W-1:0] r_idle;
    logic              w_assembling;

    assign w_assembling = (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign w_frame_to   = w_assembling && !i_rx_valid && (r_idle == IDLE_W'(FRAME_TIMEOUT - 1));

    // Inter-byte idle counter, live only while a frame is being assembled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= {IDLE_W{1'b0}};
        end else if (w_assembling && !i_rx_valid) begin
            r_idle <= r_idle + {{(IDLE_W-1){1'b0}}, 1'b1};
        end else begin
            r_idle <= {IDLE_W{1'b0}};
        end
    end
`else
    assign w_frame_to = 1'b0;
`endif

    uart_wb_resp_serializer u_resp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_bytes    (w_load_bytes),
        .i_count    (w_load_cnt),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_last     (w_last)
    );

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we_o;
    assign wbm_sel_o = {4{r_cyc}};
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_wdat;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_uart_wb_master.sv
// Randomized self-checking bench for uart_wb_master with a frame-level reference model.
module tb_uart_wb_master;

    localparam int unsigned WB_TO    = 255;
    localparam int unsigned FRAME_TO = 83340;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_frame_err;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        o_busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];

    uart_wb_master #(.WB_TIMEOUT(WB_TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_frame_err (i_frame_err),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        i_rx_data   = b;
        i_rx_valid  = 1'b1;
        i_frame_err = err;
        step();
        i_rx_valid  = 1'b0;
        i_frame_err = 1'b0;
    endtask

    // Act as the slave: ack after lat stb cycles (lat < 0: never) and report the cyc length
    task automatic bus_phase(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                             input int lat, input logic [31:0] rd, output int cyc_cnt);
        int unstable = 0;
        cyc_cnt = 0;
        check_eq("bus_cyc", wbm_cyc_o, 1);
        check_eq("bus_stb", wbm_stb_o, 1);
        check_eq("bus_we", wbm_we_o, we);
        check_eq("bus_sel", wbm_sel_o, 4'hF);
        check_eq("bus_adr", wbm_adr_o, adr);
        if (we) check_eq("bus_dat", wbm_dat_o, dat);
        while (wbm_cyc_o && cyc_cnt < 1000) begin
            if (wbm_adr_o !== adr || wbm_sel_o !== 4'hF || wbm_stb_o !== 1'b1 || wbm_we_o !== we) unstable++;
            if (lat >= 0 && cyc_cnt == lat) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rd;
            end else begin
                wbm_dat_i = $urandom;
            end
            step();
            cyc_cnt++;
            wbm_ack_i = 1'b0;
        end
        check_eq("bus_stable", unstable, 0);
        check_eq("bus_stb_drop", {wbm_stb_o, wbm_sel_o}, 5'h00);
    endtask

    // Drain the response against exp_q; ready stays low for the first bp cycles
    task automatic collect(input int bp, input bit inject);
        int         got      = 0;
        int         guard    = 0;
        int         unstable = 0;
        bit         holding  = 0;
        bit         rdy;
        logic [7:0] held     = 8'h00;
        int         n        = exp_q.size();
        while (got < n && guard < 5000) begin
            if (o_tx_valid) begin
                if (!holding) begin
                    check_eq("resp_byte", o_tx_data, exp_q[got]);
                    held    = o_tx_data;
                    holding = 1;
                end else if (o_tx_data !== held) begin
                    unstable++;
                end
                rdy        = (guard >= bp) && ($urandom_range(0, 2) != 0);
                i_tx_ready = rdy;
                if (inject && guard == 3) begin
                    i_rx_valid = 1'b1;
                    i_rx_data  = 8'h52;
                end
                step();
                if (inject && guard == 3) begin
                    check_eq("drop_pulse", dut.r_drop, 1);
                    i_rx_valid = 1'b0;
                end
                i_tx_ready = 1'b0;
                if (rdy) begin
                    got++;
                    holding = 0;
                end
            end else begin
                step();
            end
            guard++;
        end
        check_eq("resp_len", got, n);
        check_eq("resp_hold", unstable, 0);
        check_eq("idle_after", o_busy, 0);
        repeat (3) step();
        check_eq("no_extra", o_tx_valid, 0);
    endtask

    // One full frame; gap idle cycles are inserted after the second address byte
    task automatic do_frame(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input int lat, input logic [31:0] rd, input int bp,
                            input bit inject, input int gap);
        int cyc_cnt;
        bit ok;
        send_byte(we ? 8'h57 : 8'h52, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            send_byte(adr[8*i +: 8], 1'b0);
            if (i == 2 && gap > 0) begin
                repeat (gap) step();
                check_eq("partial_wait", {o_busy, wbm_cyc_o}, 2'b10);
            end
        end
        if (we) for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], 1'b0);
        bus_phase(we, adr, dat, lat, rd, cyc_cnt);
        ok = (lat >= 0) && (lat < int'(WB_TO));
        check_eq("bus_len", cyc_cnt, ok ? lat + 1 : int'(WB_TO));
        exp_q.delete();
        if (!ok) begin
            exp_q.push_back(8'h15);
        end else begin
            exp_q.push_back(8'h06);
            if (!we) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
        end
        collect(bp, inject);
    endtask

    initial begin
        int quiet;
        int n;
        rst_n       = 1'b0;
        i_rx_data   = 8'h00;
        i_rx_valid  = 1'b0;
        i_frame_err = 1'b0;
        i_tx_ready  = 1'b0;
        wbm_dat_i   = 32'h0;
        wbm_ack_i   = 1'b0;
        repeat (3) step();
        check_eq("rst_cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b000);
        check_eq("rst_sel", wbm_sel_o, 4'h0);
        check_eq("rst_adr", wbm_adr_o, 32'h0);
        check_eq("rst_dat", wbm_dat_o, 32'h0);
        check_eq("rst_tx", {o_tx_valid, o_tx_data}, 9'h000);
        check_eq("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        step();

        do_frame(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 2, 32'h0, 0, 1'b0, 0);
        do_frame(1'b0, 32'h3000_0008, 32'h0, 0, 32'h1234_5678, 50, 1'b0, 0);
        do_frame(1'b0, 32'h4000_0000, 32'h0, -1, 32'h0, 0, 1'b0, 0);
        do_frame(1'b0, 32'h3000_0010, 32'h0, int'(WB_TO) - 1, 32'hCAFE_F00D, 0, 1'b0, 0);

        send_byte(8'h41, 1'b0);
        exp_q = {8'h15};
        collect(0, 1'b0);
        do_frame(1'b1, 32'h3000_0000, 32'h0102_0304, 1, 32'h0, 0, 1'b0, 0);

        // Framing error after two address bytes aborts silently
        send_byte(8'h52, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h00, 1'b0);
        i_frame_err = 1'b1;
        step();
        i_frame_err = 1'b0;
        check_eq("ferr_idle", o_busy, 0);
        quiet = 0;
        repeat (20) begin
            if (wbm_cyc_o || o_tx_valid) quiet++;
            step();
        end
        check_eq("ferr_quiet", quiet, 0);

        send_byte(8'h57, 1'b1);
        check_eq("err_wins", o_busy, 0);

        do_frame(1'b0, $urandom, 32'h0, 1, $urandom, 6, 1'b1, 0);
        do_frame(1'b0, 32'h3000_000C, 32'h0, 0, 32'hA5A5_5A5A, 0, 1'b0, 100);

        for (int k = 0; k < 24; k++) begin
            do_frame(1'($urandom_range(0, 1)), $urandom, $urandom,
                     ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6)),
                     $urandom, int'($urandom_range(0, 4)), 1'b0, 0);
        end

        // Reset in the middle of a bus cycle
        send_byte(8'h52, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h20, 1'b0);
        check_eq("mid_cyc", wbm_cyc_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_drop", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet = 0;
        repeat (10) begin
            if (o_tx_valid || wbm_cyc_o) quiet++;
            step();
        end
        check_eq("mid_rst_quiet", quiet, 0);
        check_eq("mid_rst_busy", o_busy, 0);
        do_frame(1'b1, 32'h3000_0044, 32'h5555_AAAA, 0, 32'h0, 1, 1'b0, 0);

`ifdef UART_WB_FRAME_TIMEOUT_EN
        send_byte(8'h52, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h00, 1'b0);
        n = 0;
        while (o_busy && n < int'(FRAME_TO) + 100) begin
            step();
            n++;
        end
        check_eq("frame_to_len", (n >= int'(FRAME_TO) - 2) && (n <= int'(FRAME_TO) + 2), 1);
        check_eq("frame_to_quiet", {o_tx_valid, wbm_cyc_o}, 2'b00);
        do_frame(1'b0, 32'h3000_0018, 32'h0, 3, 32'h0BAD_F00D, 0, 1'b0, 0);
`else
        n = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Command-frame Wishbone initiator, the master-side counterpart to the memory-mapped UART slave.
- Takes received UART bytes (as produced by uart_receive) and decodes read/write command frames.
- Runs one Wishbone classic single-beat cycle per frame, then streams a response byte sequence toward uart_transmission.
- Gives host-side debug access to any Wishbone slave, including the 0x3000_00xx user region.

Parameters:
- WB_TIMEOUT, 255, max cycles cyc/stb stays asserted waiting for ack before NAK.
- FRAME_TIMEOUT, 83340, max idle cycles between bytes of one frame (two characters at 9600 baud, 40 MHz); used only with the optional feature.
- CMD_WR, 8'h57, write command byte ('W').
- CMD_RD, 8'h52, read command byte ('R').

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_rx_data  input  8  received byte; valid when i_rx_valid.
- i_rx_valid  input  1  one-cycle pulse per received byte.
- i_frame_err  input  1  one-cycle pulse; receiver framing error on the current byte.
- o_tx_data  output  8  response byte.
- o_tx_valid  output  1  response byte available.
- i_tx_ready  input  1  transmitter accepts o_tx_data this cycle.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  byte selects, always 4'hF during a cycle.
- wbm_adr_o  output  32  address.
- wbm_dat_o  output  32  write data.
- wbm_dat_i  input  32  read data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; wbm_sel_o = 4'h0; state IDLE; all counters 0.
- Frame format:
  - Write: CMD_WR, A3, A2, A1, A0, D3, D2, D1, D0 (big-endian, MSB byte first).
  - Read: CMD_RD, A3, A2, A1, A0.
- States:
  - IDLE: on i_rx_valid, byte == CMD_WR or CMD_RD → latch we, go to ADDR with byte count 0. Any other byte → go to RESP with a single NAK (8'h15).
  - ADDR: each i_rx_valid shifts the byte into the address register (adr = {adr[23:0], byte}). After the 4th byte, go to WDATA if writing, else BUS.
  - WDATA: same shifting into the write-data register. After the 4th byte, go to BUS.
  - BUS: assert cyc, stb and sel = F, with we as latched. adr and dat are stable the whole cycle.
    - Sample ack every cycle.
    - On ack: drop cyc/stb/sel on the next edge. For a read, capture wbm_dat_i in the ack cycle. Queue ACK (8'h06), plus 4 data bytes MSB first for a read.
    - If the wait counter reaches WB_TIMEOUT with no ack: drop the cycle and queue a single NAK.
    - Latency: ack on the first stb cycle gives a 1-cycle bus phase.
  - RESP: present queued bytes in order. o_tx_valid stays high and o_tx_data stable until a cycle with i_tx_ready = 1. The next byte appears the following cycle. After the last acceptance, go to IDLE.
- Rx bytes arriving in BUS or RESP are discarded. Flag this with a 1-cycle internal drop pulse; it has no port.
- i_frame_err in ADDR or WDATA: abort, go to IDLE, no response.
- i_frame_err in IDLE: that byte is ignored.
- i_frame_err and i_rx_valid in the same cycle: the error wins and the byte is ignored.
- An ack arriving in the same cycle the timeout limit is hit counts as success.
- Reset mid-cycle: cyc/stb drop asynchronously; no response is sent.
- The wait counter is $clog2(WB_TIMEOUT+1) bits and is cleared on entry to BUS.

Optional Feature:
- Macro UART_WB_FRAME_TIMEOUT_EN.
- Defined: an idle counter runs in ADDR/WDATA, clears on each i_rx_valid, and on reaching FRAME_TIMEOUT forces IDLE with no response. This recovers from truncated host frames.
- Undefined: no counter; a partial frame waits indefinitely for further bytes.

Decomposition:
- Shared package, uart_wb_pkg:
  - state enum (IDLE, ADDR, WDATA, BUS, RESP);
  - RESP_ACK = 8'h06 and RESP_NAK = 8'h15;
  - CMD_WR/CMD_RD defaults.
- One natural sub-module: uart_wb_resp_serializer. It is a 5-byte load/shift register with a count and the valid/ready output handshake.

Test Plan:
- Write: send 57 30 00 00 04 DE AD BE EF, slave acks after 2 cycles → one cycle with we = 1, adr = 3000_0004, dat_o = DEADBEEF, sel = F; response 06.
- Read: send 52 30 00 00 08, slave returns 12345678 with ack → response 06 12 34 56 78, each byte held until i_tx_ready.
- Bus timeout: read to 4000_0000 with no ack → cyc held exactly 255 cycles, then dropped; response 15.
- Bad command: byte 41 → response 15; a following valid frame completes normally.
- Framing error after 2 address bytes → IDLE, no response, no Wishbone cycle. With UART_WB_FRAME_TIMEOUT_EN, a 3-byte partial frame followed by 83340 idle cycles → IDLE, then a fresh frame succeeds.
- Backpressure and drops: hold i_tx_ready low 50 cycles during a read response → o_tx_data stable throughout. A byte injected during RESP is discarded, with no effect on the response sequence.
